game_tick_sched: RTL and testbench

GAME_TICK_SCHED -- requirements
Module: game_tick_sched

---
 rtl/game_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 32 +++
 rtl/game_tick_sched.sv | 120 ++++++++++++
 tb/tb_game_tick_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game tick scheduler.
//   game_state_t     : top-level game FSM state (IDLE/RUN/PAUSED/OVER)
//   PIPE_DIV_DEFAULT : default number of bird ticks per pipe tick
//   PDIV_W           : width of the pipe divider (PIPE_DIV legal range 1..15)
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    localparam int unsigned PIPE_DIV_DEFAULT = 2;
    localparam int unsigned PDIV_W           = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler for the bird tick.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   enable     : advance the count this cycle
//   clear      : force the count to zero (wins over enable)
//   wrap_c     : combinational, high on the enabled cycle where the count rolls over
module tick_prescaler #(
    parameter int unsigned W = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap_c
);

    logic [W-1:0] cnt;

    // Count register; natural binary rollover gives the 2**W period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    assign wrap_c = enable && (cnt == {W{1'b1}});

endmodule

// File: rtl/game_tick_sched.sv
// Game tick scheduler: game FSM, bird/pipe tick generation and flap handling.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   start       : pulse, IDLE->RUN or OVER->IDLE
//   pause       : level, freezes the game
//   flap_req    : pulse, player flap request
//   collide     : level, collision from playfield
//   step        : pulse, single tick while paused (only with GAME_TICK_SCHED_STEP_EN)
//   state       : current game state
//   bird_tick   : one-cycle pulse, move the bird
//   pipe_tick   : one-cycle pulse, shift the pipes
//   bird_up     : direction with bird_tick (1 = flap)
//   flap_ack    : pulse with a bird_tick that consumed a flap
// Optional feature macro: GAME_TICK_SCHED_STEP_EN
module game_tick_sched
    import game_pkg::*;
#(
    parameter int unsigned TICK_W   = 10,
    parameter int unsigned PIPE_DIV = PIPE_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        flap_req,
    input  logic        collide,
`ifdef GAME_TICK_SCHED_STEP_EN
    input  logic        step,
`endif
    output game_state_t state,
    output logic        bird_tick,
    output logic        pipe_tick,
    output logic        bird_up,
    output logic        flap_ack
);

    game_state_t       next_state;
    logic              run_stay_c;
    logic              presc_clear_c;
    logic              wrap_c;
    logic              step_tick_c;
    logic              tick_gen_c;
    logic              flap_take_c;
    logic              game_clear_c;
    logic [PDIV_W-1:0] pdiv;
    logic              pending;

    // Next-state logic; collide outranks pause in RUN, and is ignored in PAUSED.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN: begin
                if (collide)    next_state = OVER;
                else if (pause) next_state = PAUSED;
            end
            PAUSED:  if (!pause) next_state = RUN;
            OVER:    if (start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Prescaler only advances on cycles that stay in RUN; it is zero outside a game.
    assign run_stay_c    = (state == RUN) && (next_state == RUN);
    assign presc_clear_c = (next_state == IDLE) || (next_state == OVER);

    tick_prescaler #(
        .W (TICK_W)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .enable (run_stay_c),
        .clear  (presc_clear_c),
        .wrap_c (wrap_c)
    );

`ifdef GAME_TICK_SCHED_STEP_EN
    assign step_tick_c = (state == PAUSED) && step;
`else
    assign step_tick_c = 1'b0;
`endif

    assign tick_gen_c   = wrap_c || step_tick_c;
    assign flap_take_c  = pending || flap_req;
    assign game_clear_c = (state == IDLE) || ((state == OVER) && start);

    // State, divider, pending flap and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pdiv      <= '0;
            pending   <= 1'b0;
            bird_tick <= 1'b0;
            pipe_tick <= 1'b0;
            bird_up   <= 1'b0;
            flap_ack  <= 1'b0;
        end else begin
            state     <= next_state;
            bird_tick <= tick_gen_c;
            bird_up   <= tick_gen_c && flap_take_c;
            flap_ack  <= tick_gen_c && flap_take_c;
            pipe_tick <= 1'b0;
            if (game_clear_c) begin
                pdiv    <= '0;
                pending <= 1'b0;
            end else if (tick_gen_c) begin
                pending <= 1'b0;
                if (pdiv == PDIV_W'(PIPE_DIV - 1)) begin
                    pdiv      <= '0;
                    pipe_tick <= 1'b1;
                end else begin
                    pdiv <= pdiv + PDIV_W'(1);
                end
            end else if (flap_req && ((state == RUN) || (state == PAUSED))) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched (TICK_W=3, PIPE_DIV=2).
module tb_game_tick_sched;

    localparam int unsigned TICK_W   = 3;
    localparam int unsigned PIPE_DIV = 2;
    localparam int          PERIOD   = 1 << TICK_W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       flap_req = 1'b0;
    logic       collide = 1'b0;
    logic [1:0] state;
    logic       bird_tick;
    logic       pipe_tick;
    logic       bird_up;
    logic       flap_ack;
`ifdef GAME_TICK_SCHED_STEP_EN
    logic       step = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    game_tick_sched #(
        .TICK_W   (TICK_W),
        .PIPE_DIV (PIPE_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .flap_req  (flap_req),
        .collide   (collide),
`ifdef GAME_TICK_SCHED_STEP_EN
        .step      (step),
`endif
        .state     (state),
        .bird_tick (bird_tick),
        .pipe_tick (pipe_tick),
        .bird_up   (bird_up),
        .flap_ack  (flap_ack)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts running cycles and ticks of the current game.
    int m_state = 0;
    int m_run   = 0;
    int m_ticks = 0;
    int m_pend  = 0;
    int e_bird  = 0;
    int e_pipe  = 0;
    int e_up    = 0;

    always @(posedge clk) begin
        e_bird = 0;
        e_pipe = 0;
        e_up   = 0;
        if (!reset) begin
            m_state = 0;
            m_run   = 0;
            m_ticks = 0;
            m_pend  = 0;
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state = 1;
                    m_run   = 0;
                    m_ticks = 0;
                    m_pend  = 0;
                end
                1: begin
                    if (collide || pause) begin
                        m_state = collide ? 3 : 2;
                        if (flap_req) m_pend = 1;
                    end else begin
                        m_run++;
                        if (m_run % PERIOD == 0) begin
                            m_ticks++;
                            e_bird = 1;
                            e_pipe = (m_ticks % PIPE_DIV == 0) ? 1 : 0;
                            e_up   = (m_pend != 0 || flap_req) ? 1 : 0;
                            m_pend = 0;
                        end else if (flap_req) begin
                            m_pend = 1;
                        end
                    end
                end
                2: begin
                    if (flap_req) m_pend = 1;
                    if (!pause) m_state = 1;
                end
                default: if (start) begin
                    m_state = 0;
                    m_pend  = 0;
                end
            endcase
        end
        #1;
        check("model_state", int'(state), m_state);
        check("model_bird_tick", int'(bird_tick), e_bird);
        check("model_pipe_tick", int'(pipe_tick), e_pipe);
        check("model_bird_up", int'(bird_up), e_up);
        check("model_flap_ack", int'(flap_ack), e_up);
    end

    // Apply inputs at a falling edge, return at the next falling edge.
    task automatic cyc(input logic st, input logic fl, input logic pa, input logic co);
        start    = st;
        flap_req = fl;
        pause    = pa;
        collide  = co;
        @(negedge clk);
    endtask

    initial begin
        int first;
        int firstp;
        int nb;
        int np;
        int nack;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_bird", int'(bird_tick), 0);
        check("rst_ack", int'(flap_ack), 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("idle_wait", int'(state), 0);

        // Steady run: ticks every 8 cycles, pipe on every second tick.
        cyc(1, 0, 0, 0);
        check("run_entry", int'(state), 1);
        first = -1; firstp = -1; nb = 0; np = 0;
        for (int k = 1; k <= 32; k++) begin
            cyc(0, 0, 0, 0);
            if (bird_tick) begin nb++; if (first < 0) first = k; end
            if (pipe_tick) begin np++; if (firstp < 0) firstp = k; end
        end
        check("first_bird_cycle", first, 8);
        check("bird_count_32", nb, 4);
        check("pipe_count_32", np, 2);
        check("first_pipe_cycle", firstp, 16);

        // Two flap requests inside one tick window collapse into one.
        nack = 0;
        for (int k = 33; k <= 48; k++) begin
            cyc(0, (k == 35 || k == 37), 0, 0);
            if (flap_ack) nack++;
            if (k == 40) begin
                check("flap_tick_bird", int'(bird_tick), 1);
                check("flap_tick_up", int'(bird_up), 1);
            end
            if (k == 48) begin
                check("after_flap_bird", int'(bird_tick), 1);
                check("after_flap_up", int'(bird_up), 0);
            end
        end
        check("flap_ack_count", nack, 1);

        // Pause at cnt=5 for 20 cycles; tick resumes 3 cycles after release.
        first = -1; nb = 0;
        for (int k = 49; k <= 80; k++) begin
            cyc(0, 0, (k >= 54 && k <= 73), 0);
            if (k == 54) check("paused_state", int'(state), 2);
            if (k == 74) check("resume_state", int'(state), 1);
            if (bird_tick && k >= 54 && k <= 76) nb++;
            if (bird_tick && first < 0) first = k;
        end
        check("ticks_while_paused", nb, 0);
        check("tick_after_release", first, 77);

        // Collide and pause together: collide wins.
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        check("collide_over", int'(state), 3);
        nb = 0;
        for (int k = 0; k < 13; k++) begin
            cyc(0, 0, 0, 0);
            if (bird_tick || pipe_tick) nb++;
        end
        check("ticks_in_over", nb, 0);
        cyc(1, 0, 0, 0);
        check("over_to_idle", int'(state), 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("restart_run", int'(state), 1);
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 0);
            if (bird_tick && first < 0) first = k;
        end
        check("restart_first_tick", first, 8);

        // Reset with cnt=7: no tick, immediate outputs.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("second_game_run", int'(state), 1);
        nb = 0;
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 0, 0, 0);
            if (bird_tick) nb++;
        end
        check("pre_reset_ticks", nb, 0);
        reset = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_bird", int'(bird_tick), 0);
        check("async_rst_up", int'(bird_up), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 0, 0);
            if (bird_tick) nb++;
        end
        check("post_reset_ticks", nb, 0);
        check("post_reset_idle", int'(state), 0);

        // A flap in IDLE is not remembered into the next game.
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 0);
            if (k == 8) begin
                check("idle_flap_tick", int'(bird_tick), 1);
                check("idle_flap_up", int'(bird_up), 0);
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
